// File: rtl/tone_pkg.sv
// tone_pkg: shared key-code and note tables for the tone generators.
//   Key codes are 7-bit ASCII, one octave from C (A) up to B (J).
//   note_hz(ascii) returns the note frequency in Hz, or 0 for an unmapped code.
//   ev_state_e is the event FSM state type used by poly_tone_gen.
package tone_pkg;

  localparam logic [6:0] KeyA = 7'd65;  // C
  localparam logic [6:0] KeyW = 7'd87;  // C#
  localparam logic [6:0] KeyS = 7'd83;  // D
  localparam logic [6:0] KeyE = 7'd69;  // D#
  localparam logic [6:0] KeyD = 7'd68;  // E
  localparam logic [6:0] KeyF = 7'd70;  // F
  localparam logic [6:0] KeyT = 7'd84;  // F#
  localparam logic [6:0] KeyG = 7'd71;  // G
  localparam logic [6:0] KeyY = 7'd89;  // G#
  localparam logic [6:0] KeyH = 7'd72;  // A
  localparam logic [6:0] KeyU = 7'd85;  // A#
  localparam logic [6:0] KeyJ = 7'd74;  // B

  localparam int unsigned HzC  = 1046;
  localparam int unsigned HzCs = 1108;
  localparam int unsigned HzD  = 1174;
  localparam int unsigned HzDs = 1244;
  localparam int unsigned HzE  = 1318;
  localparam int unsigned HzF  = 1396;
  localparam int unsigned HzFs = 1480;
  localparam int unsigned HzG  = 1568;
  localparam int unsigned HzGs = 1661;
  localparam int unsigned HzA  = 1760;
  localparam int unsigned HzAs = 1865;
  localparam int unsigned HzB  = 1976;

  localparam int unsigned NoteCnt = 12;

  localparam logic [6:0] NoteKey [NoteCnt] = '{
    KeyA, KeyW, KeyS, KeyE, KeyD, KeyF, KeyT, KeyG, KeyY, KeyH, KeyU, KeyJ
  };

  localparam int unsigned NoteHz [NoteCnt] = '{
    HzC, HzCs, HzD, HzDs, HzE, HzF, HzFs, HzG, HzGs, HzA, HzAs, HzB
  };

  typedef enum logic [0:0] {StIdle, StLookup} ev_state_e;

  function automatic int unsigned note_hz(input logic [6:0] ascii);
    int unsigned hz;
    hz = 0;
    for (int i = 0; i < NoteCnt; i++) begin
      if (ascii == NoteKey[i]) hz = NoteHz[i];
    end
    return hz;
  endfunction

endpackage

// File: rtl/tone_channel.sv
// tone_channel: one square-wave voice.
//   clk, reset      : clock, asynchronous active-high reset
//   load            : take load_key/load_hp, start counting from load_hp-1 with wave low
//   clear           : release the voice; counter and wave return to 0
//   load_key        : key code stored with the voice
//   load_hp         : half-period in clock cycles
//   active          : voice holds a key
//   wave            : square wave, toggles every load_hp cycles, 0 when inactive
//   key             : stored key code
module tone_channel
  import tone_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [6:0]       load_key,
  input  logic [CNT_W-1:0] load_hp,
  output logic             active,
  output logic             wave,
  output logic [6:0]       key
);

  logic             active_q, active_d;
  logic             wave_q, wave_d;
  logic [6:0]       key_q, key_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    active_d = active_q;
    wave_d   = wave_q;
    key_d    = key_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    if (load) begin
      active_d = 1'b1;
      wave_d   = 1'b0;
      key_d    = load_key;
      hp_d     = load_hp;
      cnt_d    = load_hp - CNT_W'(1);
    end else if (clear) begin
      active_d = 1'b0;
      wave_d   = 1'b0;
      cnt_d    = '0;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        cnt_d  = hp_q - CNT_W'(1);
        wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      wave_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      wave_q   <= 1'b0;
      key_q    <= '0;
      hp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      wave_q   <= wave_d;
      key_q    <= key_d;
      hp_q     <= hp_d;
      cnt_q    <= cnt_d;
    end
  end

  assign active = active_q;
  assign wave   = wave_q;
  assign key    = key_q;

endmodule

// File: rtl/poly_tone_gen.sv
// poly_tone_gen: polyphonic key-to-tone generator.
//   Key press/release events are allocated to NUM_CH square-wave voices (lowest free first).
//   clk, reset : clock, asynchronous active-high reset
//   ev_valid / ev_ready / ev_ascii / ev_press : key event handshake (one event per 2 cycles)
//   ev_drop    : one-cycle pulse when a press finds every voice busy
//   ch_active  : per-voice busy flags
//   ch_wave    : per-voice square waves
//   speaker    : registered OR of ch_wave
//   voices     : registered count of active voices
//   freq_out   : half-period of the lowest active voice, present only when
//                POLY_TONE_FREQ_OUT_EN is defined
module poly_tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned FREQ_W = 19
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic [6:0]                  ev_ascii,
  input  logic                        ev_press,
  output logic                        ev_drop,
  output logic [NUM_CH-1:0]           ch_active,
  output logic [NUM_CH-1:0]           ch_wave,
  output logic                        speaker,
  output logic [$clog2(NUM_CH+1)-1:0] voices
`ifdef POLY_TONE_FREQ_OUT_EN
  ,
  output logic [FREQ_W-1:0]           freq_out
`endif
);

  localparam int unsigned VoicesW = $clog2(NUM_CH + 1);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("poly_tone_gen: NUM_CH must be 1..16");
  end

  // Half-period table, one entry per note, fixed at elaboration.
  logic [CNT_W-1:0] hp_tab [NoteCnt];

  for (genvar n = 0; n < NoteCnt; n++) begin : g_hp
    localparam int unsigned Hp = CLK_HZ / (2 * NoteHz[n]);
    if (Hp == 0 || (longint'(Hp) >> CNT_W) != 0) begin : g_bad_hp
      $error("poly_tone_gen: half-period does not fit CNT_W or is zero");
    end
    assign hp_tab[n] = CNT_W'(Hp);
  end

  ev_state_e           state_q, state_d;
  logic [6:0]          ascii_q, ascii_d;
  logic                press_q, press_d;
  logic                drop_q, drop_d;
  logic                speaker_q, speaker_d;
  logic [VoicesW-1:0]  voices_q, voices_d;

  logic [6:0]          ch_key [NUM_CH];
  logic [NUM_CH-1:0]   ch_load, ch_clear;
  logic [NUM_CH-1:0]   hit, free_oh;
  logic                lk_mapped;
  logic [CNT_W-1:0]    lk_hp;

  // Resolve the latched code against the note table and the current voices.
  always_comb begin
    lk_mapped = note_hz(ascii_q) != 0;
    lk_hp     = '0;
    for (int i = 0; i < NoteCnt; i++) begin
      if (ascii_q == NoteKey[i]) lk_hp = hp_tab[i];
    end
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = ch_active[i] && (ch_key[i] == ascii_q);
    end
    // Lowest clear bit of ch_active; zero when every voice is busy.
    free_oh = ~ch_active & (ch_active + NUM_CH'(1));
  end

  always_comb begin
    state_d  = state_q;
    ascii_d  = ascii_q;
    press_d  = press_q;
    drop_d   = 1'b0;
    ch_load  = '0;
    ch_clear = '0;
    unique case (state_q)
      StIdle: begin
        if (ev_valid) begin
          ascii_d = ev_ascii;
          press_d = ev_press;
          state_d = StLookup;
        end
      end
      StLookup: begin
        state_d = StIdle;
        if (press_q) begin
          if (lk_mapped && hit == '0) begin
            if (free_oh != '0) ch_load = free_oh;
            else               drop_d  = 1'b1;
          end
        end else begin
          ch_clear = hit;
        end
      end
    endcase
  end

  assign ev_ready = (state_q == StIdle);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tone_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .load     (ch_load[c]),
      .clear    (ch_clear[c]),
      .load_key (ascii_q),
      .load_hp  (lk_hp),
      .active   (ch_active[c]),
      .wave     (ch_wave[c]),
      .key      (ch_key[c])
    );
  end

  always_comb begin
    speaker_d = |ch_wave;
    voices_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      voices_d = voices_d + VoicesW'(ch_active[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ascii_q   <= '0;
      press_q   <= 1'b0;
      drop_q    <= 1'b0;
      speaker_q <= 1'b0;
      voices_q  <= '0;
    end else begin
      state_q   <= state_d;
      ascii_q   <= ascii_d;
      press_q   <= press_d;
      drop_q    <= drop_d;
      speaker_q <= speaker_d;
      voices_q  <= voices_d;
    end
  end

  assign ev_drop = drop_q;
  assign speaker = speaker_q;
  assign voices  = voices_q;

`ifdef POLY_TONE_FREQ_OUT_EN
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [6:0]        low_key;
  logic              low_found;

  always_comb begin
    low_found = 1'b0;
    low_key   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_active[i] && !low_found) begin
        low_found = 1'b1;
        low_key   = ch_key[i];
      end
    end
    freq_d = '0;
    if (low_found) begin
      for (int i = 0; i < NoteCnt; i++) begin
        if (low_key == NoteKey[i]) freq_d = FREQ_W'(hp_tab[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) freq_q <= '0;
    else       freq_q <= freq_d;
  end

  assign freq_out = freq_q;
`else
  if (FREQ_W == 0) begin : g_bad_freq_w
    $error("poly_tone_gen: FREQ_W must be nonzero");
  end
`endif

endmodule
